// File: rtl/riscv_pkg.sv
// Shared core definitions: load/store funct3 encodings,
// memory-stage FSM states and data-bus byte-enable width.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } memState_t;

    // True when the address is not aligned to the access size.
    function automatic logic isMisaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic r;
        r = 1'b0;
        case (f3)
            F3_H, F3_HU: r = lo[0];
            F3_W:        r = |lo;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Store lane steering (byte enables, replicated data) and
// load byte/half extraction with sign or zero extension.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addrLo,
    input  logic [31:0]     wdataIn,
    input  logic [31:0]     rdataIn,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    output logic [31:0]     rdataExt
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Pick the addressed byte and half out of the read word.
    always_comb begin
        byteSel = rdataIn[7:0];
        unique case (addrLo)
            2'd0: byteSel = rdataIn[7:0];
            2'd1: byteSel = rdataIn[15:8];
            2'd2: byteSel = rdataIn[23:16];
            2'd3: byteSel = rdataIn[31:24];
        endcase
        halfSel = addrLo[1] ? rdataIn[31:16] : rdataIn[15:0];
    end

    // Size-dependent lanes; funct3[2] selects zero extension.
    always_comb begin
        be       = 4'b1111;
        wdata    = wdataIn;
        rdataExt = rdataIn;
        unique case (funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << addrLo;
                wdata    = {4{wdataIn[7:0]}};
                rdataExt = funct3[2] ? {24'b0, byteSel}
                                     : {{24{byteSel[7]}}, byteSel};
            end
            2'b01: begin
                be       = addrLo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{wdataIn[15:0]}};
                rdataExt = funct3[2] ? {16'b0, halfSel}
                                     : {{16{halfSel[15]}}, halfSel};
            end
            default: begin
                be       = 4'b1111;
                wdata    = wdataIn;
                rdataExt = rdataIn;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: data-bus load/store sequencing, pipeline stall and
// MEM/WB register. Optional macro MISALIGN_TRAP_EN enables traps.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_mem,
    input  logic              MemWrite_mem,
    input  logic              MemtoReg_mem,
    input  logic              RegWrite_mem,
    input  logic [31:0]       ALUResult_mem,
    input  logic [31:0]       MemWriteData_mem,
    input  logic [2:0]        funct3_mem,
    input  logic [4:0]        rdAddr_mem,
    output logic              stall_mem,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [BE_W-1:0]   dbus_be,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    output logic              MemtoReg_wb,
    output logic              RegWrite_wb,
    output logic [31:0]       ReadData_wb,
    output logic [31:0]       ALUResult_wb,
    output logic [4:0]        rdAddr_wb,
    output logic              misalign_exc
);

    memState_t   state;
    memState_t   nextState;
    logic        misalign;
    logic        access;
    logic        writeDone;
    logic        readDone;
    logic [31:0] rdataExt;

`ifdef MISALIGN_TRAP_EN
    assign misalign = (MemRead_mem | MemWrite_mem)
                    & isMisaligned(funct3_mem, ALUResult_mem[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Misaligned accesses never reach the bus.
    assign access = (MemRead_mem | MemWrite_mem) & ~misalign;

    assign dbus_we   = MemWrite_mem;
    assign dbus_addr = {ALUResult_mem[ADDR_W-1:2], 2'b00};

    load_store_align uAlign (
        .funct3   (funct3_mem),
        .addrLo   (ALUResult_mem[1:0]),
        .wdataIn  (MemWriteData_mem),
        .rdataIn  (dbus_rdata),
        .be       (dbus_be),
        .wdata    (dbus_wdata),
        .rdataExt (rdataExt)
    );

    // Bus state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Next state, request and completion/stall decode.
    always_comb begin
        nextState = state;
        dbus_req  = 1'b0;
        writeDone = 1'b0;
        readDone  = 1'b0;
        unique case (state)
            IDLE: begin
                dbus_req = access;
                if (access && !dbus_gnt)
                    nextState = REQ;
                else if (access && MemRead_mem)
                    nextState = WAIT;
            end
            REQ: begin
                dbus_req = 1'b1;
                if (dbus_gnt)
                    nextState = MemRead_mem ? WAIT : IDLE;
            end
            WAIT: begin
                readDone = dbus_rvalid;
                if (dbus_rvalid)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        writeDone = dbus_req & dbus_gnt & MemWrite_mem;
        stall_mem = access & ~(writeDone | readDone);
    end

    // MEM/WB register: bubble while stalled, capture otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemtoReg_wb  <= 1'b0;
            RegWrite_wb  <= 1'b0;
            ReadData_wb  <= '0;
            ALUResult_wb <= '0;
            rdAddr_wb    <= '0;
        end else if (stall_mem) begin
            MemtoReg_wb <= 1'b0;
            RegWrite_wb <= 1'b0;
        end else begin
            MemtoReg_wb  <= MemtoReg_mem;
            RegWrite_wb  <= RegWrite_mem & ~misalign;
            ALUResult_wb <= ALUResult_mem;
            rdAddr_wb    <= rdAddr_mem;
            if (readDone)
                ReadData_wb <= rdataExt;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Trap pulse travels with the MEM/WB capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_exc <= 1'b0;
        else        misalign_exc <= misalign & ~stall_mem;
    end
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Inputs change 1ns after posedge; outputs sampled before next edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem;
    logic [31:0] ALUResult_mem, MemWriteData_mem;
    logic [2:0]  funct3_mem;
    logic [4:0]  rdAddr_mem;
    logic        stall_mem, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        MemtoReg_wb, RegWrite_wb;
    logic [31:0] ReadData_wb, ALUResult_wb;
    logic [4:0]  rdAddr_wb;
    logic        misalign_exc;

    int vectors = 0;
    int miscompares = 0;
    int stallCnt;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .MemRead_mem      (MemRead_mem),
        .MemWrite_mem     (MemWrite_mem),
        .MemtoReg_mem     (MemtoReg_mem),
        .RegWrite_mem     (RegWrite_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemWriteData_mem (MemWriteData_mem),
        .funct3_mem       (funct3_mem),
        .rdAddr_mem       (rdAddr_mem),
        .stall_mem        (stall_mem),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_addr        (dbus_addr),
        .dbus_wdata       (dbus_wdata),
        .dbus_be          (dbus_be),
        .dbus_gnt         (dbus_gnt),
        .dbus_rvalid      (dbus_rvalid),
        .dbus_rdata       (dbus_rdata),
        .MemtoReg_wb      (MemtoReg_wb),
        .RegWrite_wb      (RegWrite_wb),
        .ReadData_wb      (ReadData_wb),
        .ALUResult_wb     (ALUResult_wb),
        .rdAddr_wb        (rdAddr_wb),
        .misalign_exc     (misalign_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleIn();
        MemRead_mem      = 1'b0;
        MemWrite_mem     = 1'b0;
        MemtoReg_mem     = 1'b0;
        RegWrite_mem     = 1'b0;
        ALUResult_mem    = '0;
        MemWriteData_mem = '0;
        funct3_mem       = 3'b010;
        rdAddr_mem       = '0;
        dbus_gnt         = 1'b0;
        dbus_rvalid      = 1'b0;
        dbus_rdata       = '0;
    endtask

    // Load with immediate grant and rvalid one cycle later.
    task automatic runLoad(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr,
                           input logic [31:0] rdata,
                           input logic [31:0] exp);
        MemRead_mem   = 1'b1;
        MemtoReg_mem  = 1'b1;
        RegWrite_mem  = 1'b1;
        ALUResult_mem = addr;
        funct3_mem    = f3;
        rdAddr_mem    = 5'd7;
        dbus_gnt      = 1'b1;
        #1;
        check({tag, "_stall0"}, 32'(stall_mem), 32'd1);
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = rdata;
        #1;
        check({tag, "_stall1"}, 32'(stall_mem), 32'd0);
        tick();
        check({tag, "_data"}, ReadData_wb, exp);
        check({tag, "_we"}, 32'(RegWrite_wb), 32'd1);
        idleIn();
    endtask

    initial begin
        rst_n = 1'b0;
        idleIn();
        tick();
        tick();
        check("rst_regwrite", 32'(RegWrite_wb), 32'd0);
        check("rst_readdata", ReadData_wb, 32'd0);
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_exc", 32'(misalign_exc), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU-only instruction passes straight through
        RegWrite_mem  = 1'b1;
        ALUResult_mem = 32'h0000_1234;
        rdAddr_mem    = 5'd5;
        #1;
        check("alu_stall", 32'(stall_mem), 32'd0);
        check("alu_req", 32'(dbus_req), 32'd0);
        tick();
        check("alu_wb_res", ALUResult_wb, 32'h0000_1234);
        check("alu_wb_rd", 32'(rdAddr_wb), 32'd5);
        check("alu_wb_we", 32'(RegWrite_wb), 32'd1);
        idleIn();

        // SW granted immediately
        MemWrite_mem     = 1'b1;
        ALUResult_mem    = 32'h0000_0100;
        MemWriteData_mem = 32'hDEAD_BEEF;
        funct3_mem       = 3'b010;
        dbus_gnt         = 1'b1;
        #1;
        check("sw_be", 32'(dbus_be), 32'hF);
        check("sw_req", 32'(dbus_req), 32'd1);
        check("sw_we", 32'(dbus_we), 32'd1);
        check("sw_addr", dbus_addr, 32'h0000_0100);
        check("sw_wdata", dbus_wdata, 32'hDEAD_BEEF);
        check("sw_stall", 32'(stall_mem), 32'd0);
        tick();
        check("sw_wb_we", 32'(RegWrite_wb), 32'd0);
        idleIn();

        // SB lane steering
        MemWrite_mem     = 1'b1;
        ALUResult_mem    = 32'h0000_0101;
        MemWriteData_mem = 32'h1234_56A5;
        funct3_mem       = 3'b000;
        dbus_gnt         = 1'b1;
        #1;
        check("sb_be", 32'(dbus_be), 32'h2);
        check("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
        tick();
        idleIn();

        // loads with extension
        runLoad("lb", 3'b000, 32'h103, 32'h80FF_FF12, 32'hFFFF_FF80);
        runLoad("lbu", 3'b100, 32'h103, 32'h80FF_FF12, 32'h0000_0080);
        runLoad("lh", 3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
        runLoad("lhu", 3'b101, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
        runLoad("lb0", 3'b000, 32'h100, 32'h0000_007F, 32'h0000_007F);

        // SH with grant delayed 3 cycles
        MemWrite_mem     = 1'b1;
        ALUResult_mem    = 32'h0000_0102;
        MemWriteData_mem = 32'h0000_ABCD;
        funct3_mem       = 3'b001;
        stallCnt = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (stall_mem) stallCnt++;
            check("sh_be", 32'(dbus_be), 32'hC);
            check("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
            check("sh_addr", dbus_addr, 32'h0000_0100);
            check("sh_req", 32'(dbus_req), 32'd1);
            tick();
        end
        dbus_gnt = 1'b1;
        #1;
        if (stall_mem) stallCnt++;
        check("sh_stalls", stallCnt, 32'd3);
        tick();
        idleIn();

        // LW: grant after 2, rvalid 4 after grant
        MemRead_mem   = 1'b1;
        MemtoReg_mem  = 1'b1;
        RegWrite_mem  = 1'b1;
        ALUResult_mem = 32'h0000_0200;
        funct3_mem    = 3'b010;
        rdAddr_mem    = 5'd9;
        dbus_rdata    = 32'hCAFE_F00D;
        stallCnt = 0;
        for (int c = 0; c < 7; c++) begin
            dbus_gnt    = (c == 2);
            dbus_rvalid = (c == 6);
            #1;
            if (stall_mem) stallCnt++;
            tick();
            if (c < 6) check("lw_bubble", 32'(RegWrite_wb), 32'd0);
        end
        check("lw_stalls", stallCnt, 32'd6);
        check("lw_data", ReadData_wb, 32'hCAFE_F00D);
        check("lw_wb_we", 32'(RegWrite_wb), 32'd1);
        check("lw_wb_rd", 32'(rdAddr_wb), 32'd9);
        idleIn();

        // reset while in WAIT
        MemRead_mem   = 1'b1;
        RegWrite_mem  = 1'b1;
        ALUResult_mem = 32'h0000_0300;
        dbus_gnt      = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rstw_data", ReadData_wb, 32'd0);
        check("rstw_alu", ALUResult_wb, 32'd0);
        check("rstw_rd", 32'(rdAddr_wb), 32'd0);
        check("rstw_req", 32'(dbus_req), 32'd1);
        idleIn();
        tick();
        rst_n = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h5555_5555;
        #1;
        check("rvalid_idle_stall", 32'(stall_mem), 32'd0);
        tick();
        check("rvalid_idle_data", ReadData_wb, 32'd0);
        MemRead_mem   = 1'b1;
        ALUResult_mem = 32'h0000_0400;
        #1;
        check("rvalid_idle_load", 32'(stall_mem), 32'd1);
        idleIn();
        tick();

        // misaligned LW at 0x202
        MemRead_mem   = 1'b1;
        MemtoReg_mem  = 1'b1;
        RegWrite_mem  = 1'b1;
        ALUResult_mem = 32'h0000_0202;
        funct3_mem    = 3'b010;
        rdAddr_mem    = 5'd3;
`ifdef MISALIGN_TRAP_EN
        #1;
        check("mis_req", 32'(dbus_req), 32'd0);
        check("mis_stall", 32'(stall_mem), 32'd0);
        tick();
        check("mis_exc", 32'(misalign_exc), 32'd1);
        check("mis_we", 32'(RegWrite_wb), 32'd0);
        idleIn();
        tick();
        check("mis_exc_off", 32'(misalign_exc), 32'd0);
`else
        #1;
        check("mis_req", 32'(dbus_req), 32'd1);
        check("mis_addr", dbus_addr, 32'h0000_0200);
        check("mis_stall", 32'(stall_mem), 32'd1);
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1122_3344;
        tick();
        check("mis_data", ReadData_wb, 32'h1122_3344);
        check("mis_exc", 32'(misalign_exc), 32'd0);
        idleIn();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
